// File: rtl/pc_seq_if.sv
// Request/response bundle between control logic and the PC sequencer.
// The master drives redirect requests and observes the fetch address and RAS status.
interface pc_seq_if #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned RAS_CNT_W = 4
);
  logic              stall;
  logic              trap;
  logic              jmpFlag;
  logic              callFlag;
  logic              retFlag;
  logic              branchFlag;
  logic              zeroFlag;
  logic              branchOnZero;
  logic [ADDR_W-1:0] jmpAddress;
  logic [ADDR_W-1:0] branchOffset;

  logic [ADDR_W-1:0]    addr;
  logic                 flush;
  logic [ADDR_W-1:0]    epc;
  logic [RAS_CNT_W-1:0] ras_count;
  logic                 ras_overflow;
  logic                 ras_underflow;

  modport master (
    output stall, trap, jmpFlag, callFlag, retFlag, branchFlag, zeroFlag, branchOnZero,
    output jmpAddress, branchOffset,
    input  addr, flush, epc, ras_count, ras_overflow, ras_underflow
  );

  modport slave (
    input  stall, trap, jmpFlag, callFlag, retFlag, branchFlag, zeroFlag, branchOnZero,
    input  jmpAddress, branchOffset,
    output addr, flush, epc, ras_count, ras_overflow, ras_underflow
  );
endinterface

// File: rtl/pc_seq.sv
// Program-counter sequencer: increment, jump/call, return, conditional branch and trap,
// with a circular return-address stack and a registered one-cycle flush after redirects.
module pc_seq #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned RESET_ADDR  = 1040,
  parameter int unsigned JMP_BASE    = 1040,
  parameter int unsigned INSTR_BYTES = 4,
  parameter int unsigned RAS_DEPTH   = 8,
  parameter int unsigned TRAP_VECTOR = 16
) (
  input logic        CLK,
  input logic        RST,
  pc_seq_if.slave    bus_io
);

  localparam int unsigned PtrW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(RAS_DEPTH + 1);

  localparam logic [ADDR_W-1:0] ResetAddr  = ADDR_W'(RESET_ADDR);
  localparam logic [ADDR_W-1:0] JmpBase    = ADDR_W'(JMP_BASE);
  localparam logic [ADDR_W-1:0] InstrBytes = ADDR_W'(INSTR_BYTES);
  localparam logic [ADDR_W-1:0] TrapVector = ADDR_W'(TRAP_VECTOR);
  localparam logic [CntW-1:0]   RasFull    = CntW'(RAS_DEPTH);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] epc_q, epc_d;
  logic              flush_q, flush_d;
  logic [PtrW-1:0]   ptr_q, ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
  logic              ras_we;
  logic [PtrW-1:0]   top_idx;
  logic [ADDR_W-1:0] seq_addr;
  logic              br_taken;

  // ptr_q is the next write slot; the top of stack sits one below it.
  assign top_idx  = ptr_q - PtrW'(1);
  assign seq_addr = addr_q + InstrBytes;
  assign br_taken = bus_io.branchFlag && (bus_io.zeroFlag == bus_io.branchOnZero);

  always_comb begin
    addr_d  = addr_q;
    epc_d   = epc_q;
    flush_d = 1'b0;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    ras_we  = 1'b0;

    if (bus_io.trap) begin
      addr_d  = TrapVector;
      epc_d   = addr_q;
      flush_d = 1'b1;
    end else if (bus_io.stall) begin
      addr_d = addr_q;
    end else if (bus_io.retFlag) begin
      if (cnt_q != '0) begin
        addr_d  = ras_q[top_idx];
        ptr_d   = top_idx;
        cnt_d   = cnt_q - CntW'(1);
        flush_d = 1'b1;
      end else begin
        addr_d = seq_addr;
        unf_d  = 1'b1;
      end
    end else if (bus_io.jmpFlag) begin
      addr_d  = bus_io.jmpAddress + JmpBase;
      flush_d = 1'b1;
      if (bus_io.callFlag) begin
        ras_we = 1'b1;
        ptr_d  = ptr_q + PtrW'(1);
        // When full the write slot holds the oldest link, so it is simply overwritten.
        if (cnt_q == RasFull) begin
          ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
    end else if (br_taken) begin
      addr_d  = addr_q + bus_io.branchOffset + InstrBytes;
      flush_d = 1'b1;
    end else begin
      addr_d = seq_addr;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      addr_q  <= ResetAddr;
      epc_q   <= '0;
      flush_q <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      epc_q   <= epc_d;
      flush_q <= flush_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack storage needs no reset; entries are only read while cnt_q says they are valid.
  always_ff @(posedge CLK) begin
    if (!RST && ras_we) begin
      ras_q[ptr_q] <= seq_addr;
    end
  end

  assign bus_io.addr          = addr_q;
  assign bus_io.epc           = epc_q;
  assign bus_io.flush         = flush_q;
  assign bus_io.ras_count     = cnt_q;
  assign bus_io.ras_overflow  = ovf_q;
  assign bus_io.ras_underflow = unf_q;

endmodule

// File: tb/tb_pc_seq.sv
// Bench for pc_seq: directed scenarios plus randomized traffic, checked every cycle
// against a queue-based reference model of the sequencer.
module tb_pc_seq;

  localparam int unsigned AddrW = 32;
  localparam int unsigned Depth = 8;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  pc_seq_if #(.ADDR_W(AddrW), .RAS_CNT_W(4)) bus ();

  pc_seq #(
    .ADDR_W      (AddrW),
    .RESET_ADDR  (1040),
    .JMP_BASE    (1040),
    .INSTR_BYTES (4),
    .RAS_DEPTH   (Depth),
    .TRAP_VECTOR (16)
  ) u_dut (
    .CLK    (CLK),
    .RST    (RST),
    .bus_io (bus)
  );

  always #5 CLK = ~CLK;

  // Reference model state.
  logic [31:0] m_addr;
  logic [31:0] m_epc;
  logic        m_flush;
  logic        m_ovf;
  logic        m_unf;
  logic [31:0] m_ras[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp,
               $time);
    end
  endtask

  task automatic clear_inputs();
    RST = 1'b0;
    bus.stall = 1'b0;
    bus.trap = 1'b0;
    bus.jmpFlag = 1'b0;
    bus.callFlag = 1'b0;
    bus.retFlag = 1'b0;
    bus.branchFlag = 1'b0;
    bus.zeroFlag = 1'b0;
    bus.branchOnZero = 1'b0;
    bus.jmpAddress = '0;
    bus.branchOffset = '0;
  endtask

  task automatic model_edge();
    logic [31:0] seq;
    seq = m_addr + 32'd4;
    if (RST) begin
      m_addr = 32'd1040;
      m_epc = 32'd0;
      m_flush = 1'b0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_ras.delete();
    end else if (bus.trap) begin
      m_epc = m_addr;
      m_addr = 32'd16;
      m_flush = 1'b1;
    end else if (bus.stall) begin
      m_flush = 1'b0;
    end else if (bus.retFlag) begin
      if (m_ras.size() > 0) begin
        m_addr = m_ras.pop_back();
        m_flush = 1'b1;
      end else begin
        m_unf = 1'b1;
        m_addr = seq;
        m_flush = 1'b0;
      end
    end else if (bus.jmpFlag) begin
      if (bus.callFlag) begin
        if (m_ras.size() == Depth) begin
          void'(m_ras.pop_front());
          m_ovf = 1'b1;
        end
        m_ras.push_back(seq);
      end
      m_addr = bus.jmpAddress + 32'd1040;
      m_flush = 1'b1;
    end else if (bus.branchFlag && (bus.zeroFlag == bus.branchOnZero)) begin
      m_addr = m_addr + bus.branchOffset + 32'd4;
      m_flush = 1'b1;
    end else begin
      m_addr = seq;
      m_flush = 1'b0;
    end
  endtask

  // Advance one clock, update the model, and compare every output.
  task automatic step(input string tag);
    model_edge();
    @(posedge CLK);
    #1;
    check_eq({tag, ".addr"}, bus.addr, m_addr);
    check_eq({tag, ".flush"}, 32'(bus.flush), 32'(m_flush));
    check_eq({tag, ".epc"}, bus.epc, m_epc);
    check_eq({tag, ".ras_count"}, 32'(bus.ras_count), 32'(m_ras.size()));
    check_eq({tag, ".ovf"}, 32'(bus.ras_overflow), 32'(m_ovf));
    check_eq({tag, ".unf"}, 32'(bus.ras_underflow), 32'(m_unf));
  endtask

  initial begin
    logic [31:0] held;
    m_addr = '0;
    m_epc = '0;
    m_flush = 1'b0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    clear_inputs();
    #2;

    // Reset and idle run.
    RST = 1'b1;
    step("reset");
    check_eq("reset_addr_const", bus.addr, 32'd1040);
    RST = 1'b0;
    for (int i = 0; i < 3; i++) step("idle");
    check_eq("idle_addr_const", bus.addr, 32'd1052);

    // Branch taken (bne, zero=0) then not taken (zero=1).
    RST = 1'b1;
    step("reset2");
    RST = 1'b0;
    step("idle2");
    step("idle3");
    bus.branchFlag = 1'b1;
    bus.branchOnZero = 1'b0;
    bus.zeroFlag = 1'b0;
    bus.branchOffset = -32'sd8;
    step("br_taken");
    check_eq("br_taken_const", bus.addr, 32'd1044);
    bus.zeroFlag = 1'b1;
    step("br_not_taken");
    check_eq("br_not_taken_const", bus.addr, 32'd1048);
    clear_inputs();

    // Call at 1060 then return.
    step("idle4");
    step("idle5");
    step("idle6");
    bus.jmpFlag = 1'b1;
    bus.callFlag = 1'b1;
    bus.jmpAddress = 32'd100;
    step("call");
    check_eq("call_addr_const", bus.addr, 32'd1140);
    clear_inputs();
    step("idle7");
    bus.retFlag = 1'b1;
    step("ret");
    check_eq("ret_addr_const", bus.addr, 32'd1064);
    clear_inputs();

    // Nine nested calls overflow the 8-entry stack, nine returns underflow it.
    for (int i = 0; i < 9; i++) begin
      bus.jmpFlag = 1'b1;
      bus.callFlag = 1'b1;
      bus.jmpAddress = 32'(i * 64);
      step("nest_call");
    end
    check_eq("nest_ovf_const", 32'(bus.ras_overflow), 32'd1);
    clear_inputs();
    for (int i = 0; i < 9; i++) begin
      bus.retFlag = 1'b1;
      step("nest_ret");
    end
    check_eq("nest_unf_const", 32'(bus.ras_underflow), 32'd1);
    clear_inputs();

    // Stall blocks a jump; trap overrides stall.
    held = m_addr;
    bus.stall = 1'b1;
    bus.jmpFlag = 1'b1;
    bus.jmpAddress = 32'd500;
    step("stall1");
    step("stall2");
    check_eq("stall_hold", bus.addr, held);
    bus.trap = 1'b1;
    step("trap_stall");
    check_eq("trap_epc", bus.epc, held);
    clear_inputs();

    // Reset in the middle of a call chain ending at 2000.
    bus.jmpFlag = 1'b1;
    bus.callFlag = 1'b1;
    bus.jmpAddress = 32'd500;
    step("chain1");
    bus.jmpAddress = 32'd700;
    step("chain2");
    bus.jmpAddress = 32'd960;
    step("chain3");
    clear_inputs();
    RST = 1'b1;
    step("mid_reset");
    check_eq("mid_reset_count", 32'(bus.ras_count), 32'd0);
    RST = 1'b0;

    // Randomized traffic: first half call-heavy, second half return-heavy.
    for (int i = 0; i < 3000; i++) begin
      int ret_mod;
      ret_mod = (i < 1500) ? 14 : 4;
      RST = ($urandom % 250) == 0;
      bus.trap = ($urandom % 40) == 0;
      bus.stall = ($urandom % 8) == 0;
      bus.retFlag = ($urandom % ret_mod) == 0;
      bus.jmpFlag = ($urandom % 4) == 0;
      bus.callFlag = ($urandom % 3) != 0;
      bus.branchFlag = ($urandom % 3) == 0;
      bus.zeroFlag = 1'($urandom);
      bus.branchOnZero = 1'($urandom);
      bus.jmpAddress = $urandom;
      bus.branchOffset = 32'($urandom_range(0, 511)) - 32'd256;
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
